// File: rtl/echo_request_input.sv
// echo_request_input
// Host-side request stage in front of the Echo core's `say` method.
// Request words tagged with the `say` method number go into a small
// circular FIFO and are handed to the core with its ready/enable
// handshake. Words with any other method number, and words that arrive
// while the FIFO is full, are discarded and counted in a saturating
// 16-bit drop counter. The stage also answers message-size queries.
// DEPTH must be a power of two in the range 2..16 so that the pointers
// wrap naturally.

module echo_request_input #(
    parameter int DEPTH      = 4,
    parameter int SAY_METHOD = 0,
    parameter int SAY_SIZE   = 32
) (
    input  logic                     CLK,
    input  logic                     RST,

    // Host request pipe
    input  logic                     EN_requests_0_enq,
    input  logic [31:0]              requests_0_enq_v,
    input  logic [15:0]              requests_0_enq_methodNumber,
    output logic                     RDY_requests_0_enq,
    output logic                     requests_0_notFull,

    // Echo core `say` method
    output logic [31:0]              request_say_v,
    output logic                     EN_request_say,
    input  logic                     RDY_request_say,

    // Message-size query
    input  logic [15:0]              messageSize_size_methodNumber,
    output logic [15:0]              messageSize_size,
    output logic                     RDY_messageSize_size,

    // Status
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [15:0]   SAY_M    = SAY_METHOD[15:0];
    localparam logic [15:0]   SAY_SZ   = SAY_SIZE[15:0];
    localparam logic [15:0]   DROP_MAX = 16'hFFFF;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    logic full;
    logic empty;
    logic is_say;
    logic accept;
    logic drop;
    logic deliver;

    // Flags come from the registered count only, so enqueue readiness
    // never depends on what the core does this cycle. That is also why a
    // full FIFO drops an enqueue even while a word is leaving.
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    assign is_say  = (requests_0_enq_methodNumber == SAY_M);
    assign accept  = EN_requests_0_enq && is_say && !full;
    assign drop    = EN_requests_0_enq && (!is_say || full);

    // Delivery looks only at the stored count: a word accepted this cycle
    // is not visible until the next one (no bypass from input to core).
    assign deliver = !empty && RDY_request_say;

    assign EN_request_say       = deliver;
    assign request_say_v        = mem[rp];
    assign RDY_requests_0_enq   = !full;
    assign requests_0_notFull   = !full;
    assign occupancy            = cnt;
    assign messageSize_size     = (messageSize_size_methodNumber == SAY_M) ? SAY_SZ : 16'd0;
    assign RDY_messageSize_size = 1'b1;

    // Storage write on accept.
    // NOTE: the storage array is deliberately left out of reset; the count
    // alone decides which entries are meaningful, and an unreset array maps
    // onto plain RAM/flops without a reset network.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wp] <= requests_0_enq_v;
        end
    end

    // Pointer, occupancy and drop-counter bookkeeping.
    // NOTE: every register here uses non-blocking assignment so that all
    // updates see the pre-edge values, e.g. cnt and the pointers move
    // together without ordering hazards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            drop_count <= '0;
        end else begin
            if (accept) begin
                wp <= wp + PTR_ONE;
            end
            if (deliver) begin
                rp <= rp + PTR_ONE;
            end
            // Simultaneous accept and delivery leave the count unchanged.
            case ({accept, deliver})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (drop && (drop_count != DROP_MAX)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_echo_request_input.sv
// Testbench for echo_request_input (DEPTH=4, SAY_METHOD=0, SAY_SIZE=32).
// A queue-based reference model tracks the words the stage should hold and
// the number of drops; every cycle the DUT outputs are compared against it,
// and the scenario tasks add explicit checks on top.

module tb_echo_request_input;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN_requests_0_enq = 1'b0;
    logic [31:0] requests_0_enq_v = '0;
    logic [15:0] requests_0_enq_methodNumber = '0;
    logic        RDY_requests_0_enq;
    logic        requests_0_notFull;
    logic [31:0] request_say_v;
    logic        EN_request_say;
    logic        RDY_request_say = 1'b0;
    logic [15:0] messageSize_size_methodNumber = '0;
    logic [15:0] messageSize_size;
    logic        RDY_messageSize_size;
    logic [15:0] drop_count;
    logic [2:0]  occupancy;

    echo_request_input #(.DEPTH(DEPTH), .SAY_METHOD(0), .SAY_SIZE(32)) dut (
        .CLK                           (CLK),
        .RST                           (RST),
        .EN_requests_0_enq             (EN_requests_0_enq),
        .requests_0_enq_v              (requests_0_enq_v),
        .requests_0_enq_methodNumber   (requests_0_enq_methodNumber),
        .RDY_requests_0_enq            (RDY_requests_0_enq),
        .requests_0_notFull            (requests_0_notFull),
        .request_say_v                 (request_say_v),
        .EN_request_say                (EN_request_say),
        .RDY_request_say               (RDY_request_say),
        .messageSize_size_methodNumber (messageSize_size_methodNumber),
        .messageSize_size              (messageSize_size),
        .RDY_messageSize_size          (RDY_messageSize_size),
        .drop_count                    (drop_count),
        .occupancy                     (occupancy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: words held in order, and the saturating drop total.
    logic [31:0] model_q[$];
    int          model_drops = 0;

    // Values observed at the most recent sample point.
    logic        obs_en;
    logic [31:0] obs_v;
    logic [2:0]  obs_occ;
    logic        obs_rdy;
    logic [15:0] obs_drops;

    // One clock cycle: drive inputs at the falling edge, compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic cycle(input logic en, input logic [15:0] meth,
                         input logic [31:0] v, input logic rdy);
        logic [15:0] query;
        logic        exp_en;
        logic        acc;
        int          n;
        @(negedge CLK);
        EN_requests_0_enq           = en;
        requests_0_enq_methodNumber = meth;
        requests_0_enq_v            = v;
        RDY_request_say             = rdy;
        query = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
        messageSize_size_methodNumber = query;
        #1;
        n      = model_q.size();
        exp_en = (n > 0) && rdy;

        tests++;
        if (EN_request_say !== exp_en) begin
            fails++;
            $display("FAIL en_say: got %b expected %b", EN_request_say, exp_en);
        end
        tests++;
        if (occupancy !== 3'(n)) begin
            fails++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, n);
        end
        tests++;
        if (RDY_requests_0_enq !== (n < DEPTH) || requests_0_notFull !== (n < DEPTH)) begin
            fails++;
            $display("FAIL enq_ready: got rdy=%b notFull=%b expected %b",
                     RDY_requests_0_enq, requests_0_notFull, (n < DEPTH));
        end
        if (n > 0) begin
            tests++;
            if (request_say_v !== model_q[0]) begin
                fails++;
                $display("FAIL say_v: got %h expected %h", request_say_v, model_q[0]);
            end
        end
        tests++;
        if (drop_count !== 16'(model_drops)) begin
            fails++;
            $display("FAIL drop_count: got %0d expected %0d", drop_count, model_drops);
        end
        tests++;
        if (messageSize_size !== ((query == 16'd0) ? 16'd32 : 16'd0) || RDY_messageSize_size !== 1'b1) begin
            fails++;
            $display("FAIL msg_size: query %0d got %0d rdy %b", query, messageSize_size, RDY_messageSize_size);
        end

        obs_en    = EN_request_say;
        obs_v     = request_say_v;
        obs_occ   = occupancy;
        obs_rdy   = RDY_requests_0_enq;
        obs_drops = drop_count;

        @(posedge CLK);
        acc = en && (meth == 16'd0) && (n < DEPTH);
        if (exp_en) void'(model_q.pop_front());
        if (acc) model_q.push_back(v);
        else if (en && model_drops < 65535) model_drops++;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge CLK);
        EN_requests_0_enq = 1'b0;
        RDY_request_say   = 1'b1;
        #2 RST = 1'b1;
        #1;
        tests++;
        if (occupancy !== 3'd0 || EN_request_say !== 1'b0 || drop_count !== 16'd0 ||
            RDY_requests_0_enq !== 1'b1 || requests_0_notFull !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: occ=%0d en=%b drops=%0d rdy=%b notFull=%b",
                     occupancy, EN_request_say, drop_count, RDY_requests_0_enq, requests_0_notFull);
        end
        @(negedge CLK);
        RST = 1'b0;
        model_q.delete();
        model_drops = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_en !== 1'b0 || obs_occ !== 3'd0 || obs_rdy !== 1'b1) begin
            fails++;
            $display("FAIL post_reset: en=%b occ=%0d rdy=%b", obs_en, obs_occ, obs_rdy);
        end
    endtask

    task automatic test_single_word();
        cycle(1'b1, 16'd0, 32'h0000_00A5, 1'b1);
        tests++;
        if (obs_en !== 1'b0) begin
            fails++;
            $display("FAIL no_bypass: got en=%b expected 0", obs_en);
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_en !== 1'b1 || obs_v !== 32'h0000_00A5) begin
            fails++;
            $display("FAIL single_word: got en=%b v=%h expected 1/000000a5", obs_en, obs_v);
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_occ !== 3'd0 || obs_drops !== 16'd0) begin
            fails++;
            $display("FAIL single_after: occ=%0d drops=%0d expected 0/0", obs_occ, obs_drops);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 16'd0, 32'(i), 1'b0);
        tests++;
        if (obs_rdy !== 1'b0) begin
            fails++;
            $display("FAIL full_rdy: got %b expected 0", obs_rdy);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 16'd0, 32'd0, 1'b1);
            tests++;
            if (obs_en !== 1'b1 || obs_v !== 32'(i) || obs_drops !== 16'd1) begin
                fails++;
                $display("FAIL drain: got en=%b v=%0d drops=%0d expected 1/%0d/1", obs_en, obs_v, obs_drops, i);
            end
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_en !== 1'b0 || obs_occ !== 3'd0) begin
            fails++;
            $display("FAIL drained: en=%b occ=%0d expected 0/0", obs_en, obs_occ);
        end
    endtask

    task automatic test_wrong_method();
        logic [15:0] base;
        cycle(1'b1, 16'd0, 32'h1234, 1'b0);
        base = 16'(model_drops);
        cycle(1'b1, 16'd3, 32'hDEAD, 1'b0);
        cycle(1'b0, 16'd0, 32'd0, 1'b0);
        tests++;
        if (obs_drops !== base + 16'd1 || obs_occ !== 3'd1) begin
            fails++;
            $display("FAIL wrong_method: drops=%0d occ=%0d expected %0d/1", obs_drops, obs_occ, base + 16'd1);
        end
        messageSize_size_methodNumber = 16'd3;
        #1;
        tests++;
        if (messageSize_size !== 16'd0) begin
            fails++;
            $display("FAIL size_q3: got %0d expected 0", messageSize_size);
        end
        messageSize_size_methodNumber = 16'd0;
        #1;
        tests++;
        if (messageSize_size !== 16'd32) begin
            fails++;
            $display("FAIL size_q0: got %0d expected 32", messageSize_size);
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_v !== 32'h1234) begin
            fails++;
            $display("FAIL wrong_method_word: got %h expected 00001234", obs_v);
        end
    endtask

    task automatic test_full_deliver();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'd0, 32'h10 + 32'(i), 1'b0);
        cycle(1'b1, 16'd0, 32'h77, 1'b1);
        tests++;
        if (obs_occ !== 3'd4 || obs_en !== 1'b1) begin
            fails++;
            $display("FAIL full_deliver: occ=%0d en=%b expected 4/1", obs_occ, obs_en);
        end
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 16'd0, 32'd0, 1'b1);
            tests++;
            if (obs_v !== 32'h10 + 32'(i) || obs_drops !== 16'd1 || obs_occ !== 3'(4 - i)) begin
                fails++;
                $display("FAIL full_drop: v=%h drops=%0d occ=%0d expected %h/1/%0d",
                         obs_v, obs_drops, obs_occ, 32'h10 + 32'(i), 4 - i);
            end
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
    endtask

    task automatic test_streaming();
        logic [15:0] base;
        base = 16'(model_drops);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 16'd0, 32'(i), 1'b1);
            tests++;
            if (i == 0 ? (obs_en !== 1'b0) : (obs_en !== 1'b1 || obs_v !== 32'(i - 1))) begin
                fails++;
                $display("FAIL stream %0d: got en=%b v=%0d", i, obs_en, obs_v);
            end
        end
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_en !== 1'b1 || obs_v !== 32'd19 || obs_drops !== base) begin
            fails++;
            $display("FAIL stream_end: en=%b v=%0d drops=%0d expected 1/19/%0d", obs_en, obs_v, obs_drops, base);
        end
    endtask

    task automatic test_random();
        logic [15:0] meth;
        for (int i = 0; i < 400; i++) begin
            meth = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
            cycle(1'($urandom_range(0, 1)), meth, $urandom, 1'($urandom_range(0, 2) != 0));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'd0, 32'hC0 + 32'(i), 1'b0);
        cycle(1'b0, 16'd0, 32'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'd0, 32'd0, 1'b1);
            tests++;
            if (obs_en !== 1'b0 || obs_occ !== 3'd0) begin
                fails++;
                $display("FAIL reset_mid: en=%b occ=%0d expected 0/0", obs_en, obs_occ);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65540; i++) cycle(1'b1, 16'd9, 32'(i), 1'b1);
        cycle(1'b0, 16'd0, 32'd0, 1'b1);
        tests++;
        if (obs_drops !== 16'hFFFF) begin
            fails++;
            $display("FAIL saturation: got %h expected ffff", obs_drops);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_wrong_method();
        test_full_deliver();
        test_streaming();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
